// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared types and widths for the push-button debouncer
package key_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    DOWN        = 2'd2,
    RELEASE_CHK = 2'd3
  } key_state_t;

  localparam int PRESS_CNT_W = 8;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser with a selectable reset level
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - push-button debouncer with level, press/release/long strobes
// and a wrapping press counter.
module key_debounce
  import key_pkg::*;
#(
  parameter int DEB_CNT    = 10000,
  parameter int LONG_CNT   = 50000000,
  parameter int CNT_W      = 26,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   io_i,
  output logic                   key_level,
  output logic                   key_press,
  output logic                   key_release,
  output logic                   key_long,
  output logic [PRESS_CNT_W-1:0] press_cnt
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CNT - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] LONG_PRE  = CNT_W'(LONG_CNT - 2);
  localparam logic             PAD_IDLE  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic                   w_sync;
  logic                   w_k;

  key_state_t             r_state;
  logic [CNT_W-1:0]       r_deb_cnt;
  logic [CNT_W-1:0]       r_hold_cnt;
  logic                   r_long_done;
  logic                   r_level;
  logic                   r_press;
  logic                   r_release;
  logic                   r_long;
  logic [PRESS_CNT_W-1:0] r_press_cnt;

  sync_2ff #(
    .RST_VAL (PAD_IDLE)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (io_i),
    .o_q (w_sync)
  );

  // w_k is 1 whenever the synchronised pad reads "pressed"
  assign w_k = (ACTIVE_LOW != 0) ? ~w_sync : w_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_deb_cnt   <= '0;
      r_hold_cnt  <= '0;
      r_long_done <= 1'b0;
      r_level     <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_long      <= 1'b0;
      r_press_cnt <= '0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;

      // Hold timing runs through release bounces; the case below may override long_done on IDLE entry.
      if (r_state == DOWN || r_state == RELEASE_CHK) begin
        if (r_hold_cnt != LONG_LAST) begin
          r_hold_cnt <= r_hold_cnt + 1'b1;
        end
        if (r_hold_cnt == LONG_PRE && !r_long_done) begin
          r_long      <= 1'b1;
          r_long_done <= 1'b1;
        end
      end

      case (r_state)
        IDLE: begin
          if (w_k) begin
            r_state   <= PRESS_CHK;
            r_deb_cnt <= '0;
          end
        end
        PRESS_CHK: begin
          if (!w_k) begin
            r_state     <= IDLE;
            r_deb_cnt   <= '0;
            r_long_done <= 1'b0;
          end else if (r_deb_cnt == DEB_LAST) begin
            r_state     <= DOWN;
            r_deb_cnt   <= '0;
            r_hold_cnt  <= '0;
            r_press     <= 1'b1;
            r_level     <= 1'b1;
            r_press_cnt <= r_press_cnt + 1'b1;
          end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
          end
        end
        DOWN: begin
          if (!w_k) begin
            r_state   <= RELEASE_CHK;
            r_deb_cnt <= '0;
          end
        end
        RELEASE_CHK: begin
          if (w_k) begin
            r_state   <= DOWN;
            r_deb_cnt <= '0;
          end else if (r_deb_cnt == DEB_LAST) begin
            r_state     <= IDLE;
            r_deb_cnt   <= '0;
            r_release   <= 1'b1;
            r_level     <= 1'b0;
            r_long_done <= 1'b0;
          end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_deb_cnt <= '0;
        end
      endcase
    end
  end

  assign key_level   = r_level;
  assign key_press   = r_press;
  assign key_release = r_release;
  assign key_long    = r_long;
  assign press_cnt   = r_press_cnt;

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - self-checking bench for key_debounce
module tb_key_debounce;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int CW   = 26;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       io_i = 1'b1;
  logic       key_level;
  logic       key_press;
  logic       key_release;
  logic       key_long;
  logic [7:0] press_cnt;

  int checks = 0;
  int errors = 0;

  // Reference: pad history, run length of samples disagreeing with the accepted level, hold age
  logic m_s1 = 1'b1;
  logic m_s2 = 1'b1;
  bit   m_level = 1'b0;
  int   m_run = 0;
  int   m_age = 0;
  int   m_cnt = 0;
  bit   m_press = 1'b0;
  bit   m_rel = 1'b0;
  bit   m_long = 1'b0;

  int n_press = 0;
  int n_rel = 0;
  int n_long = 0;

  key_debounce #(
    .DEB_CNT    (DEB),
    .LONG_CNT   (LONG),
    .CNT_W      (CW),
    .ACTIVE_LOW (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .io_i        (io_i),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long),
    .press_cnt   (press_cnt)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic pad, input logic r);
    bit k;
    io_i = pad;
    rst  = r;
    @(posedge clk);
    if (r) begin
      m_s1 = 1'b1; m_s2 = 1'b1;
      m_level = 1'b0; m_run = 0; m_age = 0; m_cnt = 0;
      m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;
    end else begin
      k = (m_s2 == 1'b0);
      m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;
      if (m_level) begin
        m_age++;
        m_long = (m_age == LONG - 1);
      end
      if (k != m_level) m_run++;
      else m_run = 0;
      if (m_run == DEB + 1) begin
        m_run = 0;
        if (!m_level) begin
          m_press = 1'b1;
          m_cnt = (m_cnt + 1) % 256;
          m_age = 0;
        end else begin
          m_rel = 1'b1;
        end
        m_level = !m_level;
      end
      m_s2 = m_s1;
      m_s1 = pad;
    end
    #1;
    chk("level", key_level, m_level);
    chk("press", key_press, m_press);
    chk("release", key_release, m_rel);
    chk("long", key_long, m_long);
    chk("press_cnt", press_cnt, m_cnt);
    chk("press_release_excl", key_press & key_release, 0);
    n_press += int'(key_press);
    n_rel   += int'(key_release);
    n_long  += int'(key_long);
  endtask

  initial begin
    int t;
    int p0;
    int r0;
    int l0;
    int lt;

    repeat (3) tick(1'b1, 1'b1);
    chk("rst_level", key_level, 0);
    chk("rst_press", key_press, 0);
    chk("rst_cnt", press_cnt, 0);
    repeat (5) tick(1'b1, 1'b0);

    // Clean press
    t = 0;
    do begin tick(1'b0, 1'b0); t++; end while (!key_press && t < 30);
    chk("clean_press_latency", t, DEB + 3);
    chk("clean_level", key_level, 1);
    chk("clean_cnt", press_cnt, 1);

    // Release with bounce
    p0 = n_press; r0 = n_rel;
    tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0);
    t = 0;
    do begin tick(1'b1, 1'b0); t++; end while (!key_release && t < 30);
    chk("release_latency", t, DEB + 3);
    repeat (10) tick(1'b1, 1'b0);
    chk("release_once", n_rel - r0, 1);
    chk("release_no_press", n_press - p0, 0);
    chk("release_level", key_level, 0);

    // Press bounce
    p0 = n_press;
    repeat (3) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b0);
    repeat (10) tick(1'b1, 1'b0);
    chk("bounce_no_press", n_press - p0, 0);
    chk("bounce_level", key_level, 0);
    chk("bounce_idle", dut.r_state, 0);

    // Long press, twice
    for (int rep = 0; rep < 2; rep++) begin
      t = 0;
      do begin tick(1'b0, 1'b0); t++; end while (!key_press && t < 30);
      chk("long_press_seen", key_press, 1);
      l0 = n_long; lt = -1;
      for (int i = 1; i <= 40; i++) begin
        tick(1'b0, 1'b0);
        if (key_long && lt < 0) lt = i;
      end
      chk("long_once", n_long - l0, 1);
      chk("long_offset", lt, LONG - 1);
      t = 0;
      do begin tick(1'b1, 1'b0); t++; end while (!key_release && t < 30);
      chk("long_released", key_release, 1);
      repeat (4) tick(1'b1, 1'b0);
    end

    // Counter wrap from a fresh reset
    repeat (2) tick(1'b1, 1'b1);
    for (int i = 0; i < 256; i++) begin
      repeat (8) tick(1'b0, 1'b0);
      repeat (8) tick(1'b1, 1'b0);
      if (i == 254) chk("cnt_255", press_cnt, 255);
    end
    chk("cnt_wrap", press_cnt, 0);

    // Reset while pressed, then still held
    t = 0;
    do begin tick(1'b0, 1'b0); t++; end while (!key_press && t < 30);
    repeat (3) tick(1'b0, 1'b0);
    r0 = n_rel;
    repeat (2) tick(1'b0, 1'b1);
    chk("midrst_level", key_level, 0);
    chk("midrst_cnt", press_cnt, 0);
    chk("midrst_no_release", n_rel - r0, 0);
    t = 0;
    do begin tick(1'b0, 1'b0); t++; end while (!key_press && t < 30);
    chk("post_rst_latency", t, DEB + 3);
    chk("post_rst_cnt", press_cnt, 1);

    // Randomised runs with occasional reset
    for (int blk = 0; blk < 400; blk++) begin
      logic pad;
      int len;
      pad = logic'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 30)) : int'($urandom_range(1, 7));
      for (int i = 0; i < len; i++) begin
        tick(pad, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
